fifo_rd_port: RTL and testbench
===============================

Name: fifo_rd_port

Overview:
- Single-clock read-side controller for the video-scale FIFO storage array.
- Owns the read pointer and drives the array's read address and read enable.
- Absorbs the array's read latency, combinational (fall-through) or one-cycle registered, and presents a valid/ready stream to the downstream scaler stage.
- Reports its read pointer back to the write side for full detection. Both sides share one clock, so no pointer synchronisation is needed.

Parameters:
- DATASIZE, 8: word width, matching the storage array.
- ADDRSIZE, 4: array address bits; depth is 2^ADDRSIZE.
- FALLTHROUGH, "TRUE": "TRUE" means array read data is valid in the same cycle as the address; "FALSE" means it is valid one cycle after a read-enabled address.

Ports:
- clk  in  1  single clock for the block, the array read port and the write side.
- rst  in  1  synchronous, active-high reset.
- wptr  in  ADDRSIZE+1  write pointer from the write side, binary, extra MSB is the wrap bit.
- rptr  out  ADDRSIZE+1  read pointer to the write side, binary, extra MSB is the wrap bit.
- raddr  out  ADDRSIZE  array read address, equal to rptr[ADDRSIZE-1:0].
- rclken  out  1  array read enable; high only when a read is issued.
- rdata  in  DATASIZE  array read data.
- m_valid  out  1  output word valid.
- m_data  out  DATASIZE  output word.
- m_ready  in  1  downstream accept.
- empty  out  1  combinational, high when rptr == wptr.

Behaviour:
- Everything is sampled on the rising edge of clk. rst dominates every other input.
- Reset values: rptr=0, rclken=0, m_valid=0, m_data=0. The skid buffer is cleared and any in-flight read is dropped.
- Reset in the middle of a transfer discards buffered and in-flight words with no further m_valid.
- Empty: empty = (rptr == wptr), including the wrap bit.
- Full is not this block's concern. The write side compares pointers with differing MSB and equal low bits.
- Output stage is a 2-entry skid buffer. m_data is always driven from a register, never directly from rdata.
- Read issue rule, evaluated combinationally: issue = !empty && (occ + inflight < 2 || (m_valid && m_ready)).
  - occ is the number of skid entries (0..2).
  - inflight is 1 when FALLTHROUGH="FALSE" and a read was issued in the previous cycle; otherwise 0.
  - When issue is high: rclken=1, and rptr increments by 1 at the clock edge.
- rptr wraps modulo 2^(ADDRSIZE+1); raddr therefore wraps 2^ADDRSIZE-1 to 0.
- Read data capture:
  - FALLTHROUGH="TRUE": rdata is captured into the skid buffer at the same edge as issue.
  - FALLTHROUGH="FALSE": rdata is captured one edge later.
- Latency from the wptr change that makes empty low to m_valid=1: 1 cycle for "TRUE", 2 cycles for "FALSE".
- Throughput: with m_ready held high and a non-empty FIFO, one word per cycle in both modes, with no bubbles.
- Handshake:
  - Transfer occurs when m_valid && m_ready.
  - Once m_valid is asserted, m_valid and m_data stay stable until the transfer.
  - Words leave in strict FIFO order.
- Simultaneous capture and transfer in the same cycle leaves occ unchanged. occ never exceeds 2; exceeding it is a design error.
- Simultaneous write (wptr advance) and last-word read: empty follows the new pointer values the next cycle. No word is lost or duplicated.

Optional Feature:
- Macro: FIFO_RD_PORT_LEVEL_EN.
- Defined: adds output `rlevel [ADDRSIZE:0]`, equal to (wptr - rptr) mod 2^(ADDRSIZE+1), registered, reset value 0, updated every cycle. Also adds output `almost_empty`, registered, high when rlevel <= 1, reset value 1.
- Not defined: neither port exists, and there is no extra logic.

Test Plan:
- Reset behaviour: assert rst for 3 cycles with wptr=5 and m_ready=1 -> rptr=0, m_valid=0 and rclken=0 throughout; after release, the first m_data equals array word 0.
- Fall-through latency: FALLTHROUGH="TRUE", wptr steps 0->1 with array[0]=0xA5 -> m_valid=1 with m_data=0xA5 one cycle later; rptr=1; empty=1.
- Registered read, full rate: FALLTHROUGH="FALSE", 16 words 0x00..0x0F preloaded, wptr=16, m_ready=1 -> first m_valid 2 cycles after reset release; 16 consecutive transfers 0x00..0x0F; rptr ends at 16 with MSB set; empty=1.
- Backpressure: FALLTHROUGH="FALSE", 4 words, m_ready low for 5 cycles then high -> m_data holds word 0 stable; at most 2 reads issued while stalled; then words 0..3 are delivered in order with none duplicated.
- Wrap-around: ADDRSIZE=4, rptr starting at 14, 4 words written -> raddr sequence 14, 15, 0, 1; rptr goes 14->18; data order preserved.
- Reset mid-stream: rst asserted while occ=2 and a read is in flight -> next cycle m_valid=0 and rptr=0; no stale word appears after release.

Source files
------------

// File: rtl/fifo_rd_port.sv
// Read-side controller for the FIFO storage array: owns rptr, absorbs array read latency
// and feeds a 2-entry skid buffer. Optional level outputs under FIFO_RD_PORT_LEVEL_EN.
module fifo_rd_port #(
  parameter int    DATASIZE    = 8,
  parameter int    ADDRSIZE    = 4,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  input  logic [DATASIZE-1:0] rdata,
  output logic                m_valid,
  output logic [DATASIZE-1:0] m_data,
  input  logic                m_ready,
  output logic                empty
`ifdef FIFO_RD_PORT_LEVEL_EN
  ,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                almost_empty
`endif
);

  localparam bit FT = (FALLTHROUGH == "TRUE");

  // m_data is skid entry 0 (head); buf1_q is entry 1.
  logic [1:0]          occ_q, occ_nxt;
  logic                inflight_q;
  logic                inflight;
  logic [DATASIZE-1:0] buf1_q, buf1_nxt, head_nxt;
  logic [1:0]          pending;
  logic                issue, capture, xfer;

  assign empty    = (rptr == wptr);
  assign raddr    = rptr[ADDRSIZE-1:0];
  assign m_valid  = (occ_q != 2'd0);
  assign xfer     = m_valid && m_ready;
  assign inflight = FT ? 1'b0 : inflight_q;
  assign pending  = occ_q + {1'b0, inflight};

  // A read may be issued whenever the word it returns is guaranteed a skid slot.
  assign issue   = !rst && !empty && ((pending < 2'd2) || xfer);
  assign rclken  = issue;
  assign capture = FT ? issue : inflight_q;

  always_comb begin
    occ_nxt  = occ_q;
    head_nxt = m_data;
    buf1_nxt = buf1_q;
    case ({capture, xfer})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_nxt = rdata;
          occ_nxt  = 2'd1;
        end else begin
          buf1_nxt = rdata;
          occ_nxt  = 2'd2;
        end
      end
      2'b01: begin
        head_nxt = buf1_q;
        occ_nxt  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_nxt = rdata;
        end else begin
          head_nxt = buf1_q;
          buf1_nxt = rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr       <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      m_data     <= '0;
      buf1_q     <= '0;
    end else begin
      rptr       <= rptr + {{ADDRSIZE{1'b0}}, issue};
      occ_q      <= occ_nxt;
      inflight_q <= FT ? 1'b0 : issue;
      m_data     <= head_nxt;
      buf1_q     <= buf1_nxt;
    end
  end

`ifdef FIFO_RD_PORT_LEVEL_EN
  logic [ADDRSIZE:0] level_nxt;

  assign level_nxt = wptr - rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rlevel       <= '0;
      almost_empty <= 1'b1;
    end else begin
      rlevel       <= level_nxt;
      almost_empty <= (level_nxt <= {{ADDRSIZE{1'b0}}, 1'b1});
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port: one fall-through and one registered-read instance share clock,
// write pointer and downstream ready; each is scored against a queue of written words.
module tb_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] wptr = '0;
  logic       m_ready = 1'b0;
  logic [7:0] mem [16];

  logic [4:0] rptr_ft, rptr_rg;
  logic [3:0] raddr_ft, raddr_rg;
  logic       rclken_ft, rclken_rg;
  logic [7:0] rdata_ft, rdata_rg;
  logic       m_valid_ft, m_valid_rg;
  logic [7:0] m_data_ft, m_data_rg;
  logic       empty_ft, empty_rg;
`ifdef FIFO_RD_PORT_LEVEL_EN
  logic [4:0] rlevel_ft, rlevel_rg;
  logic       almost_empty_ft, almost_empty_rg;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_ft[$];
  logic [7:0] exp_rg[$];
  logic [3:0] raddr_log[$];

  always #5 clk = ~clk;

  assign rdata_ft = mem[raddr_ft];
  always @(posedge clk) if (rclken_rg) rdata_rg <= mem[raddr_rg];

  fifo_rd_port #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE")) dut_ft (
    .clk(clk), .rst(rst), .wptr(wptr), .rptr(rptr_ft), .raddr(raddr_ft),
    .rclken(rclken_ft), .rdata(rdata_ft), .m_valid(m_valid_ft), .m_data(m_data_ft),
    .m_ready(m_ready), .empty(empty_ft)
`ifdef FIFO_RD_PORT_LEVEL_EN
    , .rlevel(rlevel_ft), .almost_empty(almost_empty_ft)
`endif
  );

  fifo_rd_port #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE")) dut_rg (
    .clk(clk), .rst(rst), .wptr(wptr), .rptr(rptr_rg), .raddr(raddr_rg),
    .rclken(rclken_rg), .rdata(rdata_rg), .m_valid(m_valid_rg), .m_data(m_data_rg),
    .m_ready(m_ready), .empty(empty_rg)
`ifdef FIFO_RD_PORT_LEVEL_EN
    , .rlevel(rlevel_rg), .almost_empty(almost_empty_rg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: data order, hold-while-stalled, pointer relations.
  logic [4:0] del_ft, del_rg, diff_ft, diff_rg;
  logic       pv_ft, pr_ft, pv_rg, pr_rg;
  logic [7:0] pd_ft, pd_rg;
`ifdef FIFO_RD_PORT_LEVEL_EN
  logic [4:0] plvl;
`endif

  always @(negedge clk) begin
    if (rst) begin
      del_ft = '0;
      pv_ft = 1'b0;
`ifdef FIFO_RD_PORT_LEVEL_EN
      plvl = '0;
`endif
    end else begin
      diff_ft = rptr_ft - del_ft;
      chk("ft_raddr", raddr_ft, rptr_ft[3:0]);
      chk("ft_empty", empty_ft, rptr_ft == wptr);
      chk("ft_outstanding", diff_ft <= 5'd2, 1);
      if (pv_ft && !pr_ft) begin
        chk("ft_hold_valid", m_valid_ft, 1);
        chk("ft_hold_data", m_data_ft, pd_ft);
      end
      if (m_valid_ft && m_ready) begin
        if (exp_ft.size() == 0) chk("ft_extra_word", m_data_ft, 32'hDEAD);
        else chk("ft_data", m_data_ft, exp_ft.pop_front());
        del_ft = del_ft + 5'd1;
      end
`ifdef FIFO_RD_PORT_LEVEL_EN
      chk("ft_rlevel", rlevel_ft, plvl);
      chk("ft_almost_empty", almost_empty_ft, plvl <= 5'd1);
      plvl = wptr - rptr_ft;
`endif
      pv_ft = m_valid_ft;
      pr_ft = m_ready;
      pd_ft = m_data_ft;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      del_rg = '0;
      pv_rg = 1'b0;
    end else begin
      diff_rg = rptr_rg - del_rg;
      if (rclken_rg) raddr_log.push_back(raddr_rg);
      chk("rg_raddr", raddr_rg, rptr_rg[3:0]);
      chk("rg_empty", empty_rg, rptr_rg == wptr);
      chk("rg_outstanding", diff_rg <= 5'd2, 1);
      if (pv_rg && !pr_rg) begin
        chk("rg_hold_valid", m_valid_rg, 1);
        chk("rg_hold_data", m_data_rg, pd_rg);
      end
      if (m_valid_rg && m_ready) begin
        if (exp_rg.size() == 0) chk("rg_extra_word", m_data_rg, 32'hDEAD);
        else chk("rg_data", m_data_rg, exp_rg.pop_front());
        del_rg = del_rg + 5'd1;
      end
      pv_rg = m_valid_rg;
      pr_rg = m_ready;
      pd_rg = m_data_rg;
    end
  end

  // Driver tasks
  task automatic write_now(input logic [7:0] d);
    mem[wptr[3:0]] = d;
    exp_ft.push_back(d);
    exp_rg.push_back(d);
    wptr = wptr + 5'd1;
  endtask

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1;
    write_now(d);
  endtask

  // Holds reset, checks idle outputs, then expects mem[0..wp-1] after release.
  task automatic do_reset(input int cycles, input logic [4:0] wp);
    rst = 1'b1;
    wptr = wp;
    @(posedge clk);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_rptr_ft", rptr_ft, 0);
      chk("rst_rptr_rg", rptr_rg, 0);
      chk("rst_valid_ft", m_valid_ft, 0);
      chk("rst_valid_rg", m_valid_rg, 0);
      chk("rst_rclken_ft", rclken_ft, 0);
      chk("rst_rclken_rg", rclken_rg, 0);
    end
    exp_ft.delete();
    exp_rg.delete();
    for (int i = 0; i < int'(wp); i++) begin
      exp_ft.push_back(mem[i[3:0]]);
      exp_rg.push_back(mem[i[3:0]]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      done = (exp_ft.size() == 0) && (exp_rg.size() == 0) && !m_valid_ft && !m_valid_rg
             && empty_ft && empty_rg;
    end
    chk(tag, done, 1);
  endtask

  initial begin : stimulus
    int n_ft, n_rg;
    logic [4:0] sp_ft, sp_rg;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

    // Reset held with a non-empty pointer; first word out must be mem[0]
    m_ready = 1'b1;
    do_reset(3, 5'd5);
    drain("drain_after_reset");
    chk("reset_rptr_ft_end", rptr_ft, 5);
    chk("reset_rptr_rg_end", rptr_rg, 5);

    // Fall-through latency: one cycle; registered: two cycles
    m_ready = 1'b0;
    do_reset(2, 5'd0);
    repeat (2) @(negedge clk);
    chk("idle_valid_ft", m_valid_ft, 0);
    chk("idle_empty_ft", empty_ft, 1);
    write_word(8'hA5);
    @(negedge clk);
    chk("lat_rclken_ft", rclken_ft, 1);
    chk("lat_valid0_ft", m_valid_ft, 0);
    @(negedge clk);
    chk("lat_valid1_ft", m_valid_ft, 1);
    chk("lat_data_ft", m_data_ft, 8'hA5);
    chk("lat_rptr_ft", rptr_ft, 1);
    chk("lat_empty_ft", empty_ft, 1);
    chk("lat_valid1_rg", m_valid_rg, 0);
    @(negedge clk);
    chk("lat_valid2_rg", m_valid_rg, 1);
    chk("lat_data_rg", m_data_rg, 8'hA5);
    drain("drain_latency");

    // Registered read at full rate: 16 words back to back
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    m_ready = 1'b1;
    do_reset(2, 5'd16);
    @(negedge clk);
    chk("fr_valid_c0", m_valid_rg, 0);
    @(negedge clk);
    chk("fr_valid_c1", m_valid_rg, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("fr_valid", m_valid_rg, 1);
      chk("fr_word", m_data_rg, k);
    end
    chk("fr_rptr", rptr_rg, 5'b10000);
    chk("fr_empty", empty_rg, 1);
    drain("drain_full_rate");

    // Backpressure: four words, ready low five cycles
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    m_ready = 1'b0;
    do_reset(1, 5'd4);
    n_ft = 0;
    n_rg = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_ft += int'(rclken_ft);
      n_rg += int'(rclken_rg);
    end
    chk("bp_reads_ft", n_ft, 2);
    chk("bp_reads_rg", n_rg, 2);
    chk("bp_head_rg", m_data_rg, mem[0]);
    chk("bp_rptr_rg", rptr_rg, 2);
    @(posedge clk); #1;
    drain("drain_backpressure");
    chk("bp_rptr_end", rptr_rg, 4);

    // Wrap-around of the array address
    do_reset(1, 5'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) write_word(8'($urandom));
    drain("drain_pre_wrap");
    chk("wrap_start", rptr_rg, 14);
    raddr_log.delete();
    for (int i = 0; i < 4; i++) write_word(8'($urandom));
    drain("drain_wrap");
    chk("wrap_nreads", raddr_log.size(), 4);
    if (raddr_log.size() == 4) begin
      chk("wrap_a0", raddr_log[0], 14);
      chk("wrap_a1", raddr_log[1], 15);
      chk("wrap_a2", raddr_log[2], 0);
      chk("wrap_a3", raddr_log[3], 1);
    end
    chk("wrap_rptr_rg", rptr_rg, 18);
    chk("wrap_rptr_ft", rptr_ft, 18);

    // Reset mid-stream with the skid buffer full and a read in flight
    do_reset(1, 5'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(8'($urandom));
    @(negedge clk);
    chk("mid_valid_before", m_valid_rg, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    wptr = '0;
    exp_ft.delete();
    exp_rg.delete();
    @(negedge clk);
    chk("mid_rclken_rg", rclken_rg, 0);
    @(negedge clk);
    chk("mid_valid_rg", m_valid_rg, 0);
    chk("mid_valid_ft", m_valid_ft, 0);
    chk("mid_rptr_rg", rptr_rg, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_no_stale_ft", m_valid_ft, 0);
      chk("mid_no_stale_rg", m_valid_rg, 0);
    end

    // Randomised traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      sp_ft = wptr - rptr_ft;
      sp_rg = wptr - rptr_rg;
      if ($urandom_range(0, 2) != 0 && sp_ft < 5'd16 && sp_rg < 5'd16)
        write_now(8'($urandom));
    end
    drain("drain_random");
    chk("rand_rptr_ft", rptr_ft, wptr);
    chk("rand_rptr_rg", rptr_rg, wptr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
